// File: rtl/matrix_entry.sv
// Keypad writer for the 2x2 matrix operand set: collects 3-digit decimal entries,
// converts them from BCD to binary and stores them as 8-bit elements a11..b22.
module matrix_entry #(
   parameter int          N_ELEM    = 8,
   parameter logic [3:0]  KEY_ENTER = 4'hA,
   parameter logic [3:0]  KEY_CLEAR = 4'hB,
   localparam int         IDX_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic [8*N_ELEM-1:0]   elem_flat,
   output logic [11:0]           entry_bcd,
   output logic [1:0]            digit_cnt,
   output logic [IDX_W-1:0]      wr_idx,
   output logic                  wr_pulse,
   output logic                  err,
   output logic                  done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ENTRY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   // Digits are always 0-9, so the largest entry (999) fits the 10-bit result.
   function automatic logic [9:0] bcd_to_bin(input logic [11:0] bcd);
      return ({6'd0, bcd[11:8]} * 10'd100) + ({6'd0, bcd[7:4]} * 10'd10) + {6'd0, bcd[3:0]};
   endfunction

   logic              kv_d_r;
   logic [1:0]        state_r, state_s;
   logic [7:0]        elem_r [N_ELEM];
   logic [11:0]       entry_r, entry_s;
   logic [1:0]        cnt_r, cnt_s;
   logic [IDX_W-1:0]  idx_r, idx_s;
   logic              pulse_r, pulse_s;
   logic              err_r, err_s;
   logic              done_r, done_s;
   logic              store_s;
   logic              press_s;
   logic              is_digit_s;
   logic [9:0]        value_s;

   assign press_s    = key_valid & ~kv_d_r;
   assign is_digit_s = (key_code <= 4'd9);
   assign value_s    = bcd_to_bin(entry_r);

   // Next-state decode of one press event against the current entry state.
   always_comb begin
      state_s = state_r;
      entry_s = entry_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      pulse_s = 1'b0;
      done_s  = done_r;
      store_s = 1'b0;
      if (press_s) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
      case (state_r)
         ST_IDLE, ST_ENTRY: begin
            if (press_s && is_digit_s && (cnt_r != 2'd3)) begin
               entry_s = {entry_r[7:0], key_code};
               cnt_s   = cnt_r + 2'd1;
               state_s = ST_ENTRY;
            end else if (press_s && (key_code == KEY_ENTER) && (state_r == ST_ENTRY)) begin
               entry_s = 12'h000;
               cnt_s   = 2'd0;
               state_s = ST_IDLE;
               if (value_s <= 10'd255) begin
                  store_s = 1'b1;
                  pulse_s = 1'b1;
                  if (idx_r == LAST_IDX) begin
                     done_s  = 1'b1;
                     state_s = ST_DONE;
                  end else begin
                     idx_s = idx_r + IDX_W'(1);
                  end
               end else begin
                  err_s = 1'b1;
               end
            end else if (press_s && (key_code == KEY_CLEAR)) begin
               entry_s = 12'h000;
               cnt_s   = 2'd0;
               state_s = ST_IDLE;
            end else begin
               state_s = state_r;
            end
         end
         ST_DONE: begin
            if (press_s && (key_code == KEY_CLEAR)) begin
               done_s  = 1'b0;
               idx_s   = '0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            entry_s = 12'h000;
            cnt_s   = 2'd0;
            done_s  = 1'b0;
         end
      endcase
   end

   // State, entry and element storage registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kv_d_r  <= 1'b0;
         state_r <= ST_IDLE;
         entry_r <= 12'h000;
         cnt_r   <= 2'd0;
         idx_r   <= '0;
         pulse_r <= 1'b0;
         err_r   <= 1'b0;
         done_r  <= 1'b0;
         for (int k = 0; k < N_ELEM; k++) begin
            elem_r[k] <= 8'h00;
         end
      end else begin
         kv_d_r  <= key_valid;
         state_r <= state_s;
         entry_r <= entry_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         pulse_r <= pulse_s;
         err_r   <= err_s;
         done_r  <= done_s;
         if (store_s) begin
            elem_r[idx_r] <= value_s[7:0];
         end
      end
   end

   for (genvar k = 0; k < N_ELEM; k++) begin : g_flat
      assign elem_flat[8*k +: 8] = elem_r[k];
   end

   assign entry_bcd = entry_r;
   assign digit_cnt = cnt_r;
   assign wr_idx    = idx_r;
   assign wr_pulse  = pulse_r;
   assign err       = err_r;
   assign done      = done_r;

endmodule

// File: tb/tb_matrix_entry.sv
// Bench for matrix_entry: directed keypad scenarios plus random key traffic,
// all checked each cycle against a number-level model of the keypad writer.
module tb_matrix_entry;

   localparam int N = 8;

   logic          clk       = 1'b0;
   logic          resetn    = 1'b1;
   logic          key_valid = 1'b0;
   logic [3:0]    key_code  = 4'h0;
   logic [63:0]   elem_flat;
   logic [11:0]   entry_bcd;
   logic [1:0]    digit_cnt;
   logic [2:0]    wr_idx;
   logic          wr_pulse;
   logic          err;
   logic          done;

   matrix_entry #(.N_ELEM(N), .KEY_ENTER(4'hA), .KEY_CLEAR(4'hB)) dut (
      .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
      .elem_flat(elem_flat), .entry_bcd(entry_bcd), .digit_cnt(digit_cnt),
      .wr_idx(wr_idx), .wr_pulse(wr_pulse), .err(err), .done(done)
   );

   always #5 clk = ~clk;

   int   n_checks   = 0;
   int   n_fail     = 0;
   int   pulse_seen = 0;
   bit   chk_en     = 1'b0;

   // Model: the pending entry is kept as a plain number plus a digit count.
   int         m_num, m_nd, m_idx;
   bit         m_done, m_err, m_pulse, m_kv;
   logic [7:0] m_elem [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_flat();
      logic [63:0] f;
      f = 64'd0;
      for (int k = 0; k < N; k++) f[8*k +: 8] = m_elem[k];
      return f;
   endfunction

   function automatic logic [11:0] m_bcd();
      return {4'(m_num / 100), 4'((m_num / 10) % 10), 4'(m_num % 10)};
   endfunction

   task automatic model_reset();
      m_num = 0; m_nd = 0; m_idx = 0;
      m_done = 1'b0; m_err = 1'b0; m_pulse = 1'b0; m_kv = 1'b0;
      for (int k = 0; k < N; k++) m_elem[k] = 8'h00;
   endtask

   task automatic model_step(input bit kv, input logic [3:0] code);
      bit press;
      press   = kv && !m_kv;
      m_kv    = kv;
      m_pulse = 1'b0;
      if (press) begin
         m_err = 1'b0;
         if (m_done) begin
            if (code == 4'hB) begin
               m_done = 1'b0;
               m_idx  = 0;
            end
         end else if (code <= 4'd9) begin
            if (m_nd < 3) begin
               m_num = m_num * 10 + int'(code);
               m_nd++;
            end
         end else if (code == 4'hA) begin
            if (m_nd > 0) begin
               if (m_num <= 255) begin
                  m_elem[m_idx] = 8'(m_num);
                  m_pulse = 1'b1;
                  if (m_idx == N - 1) m_done = 1'b1;
                  else m_idx++;
               end else begin
                  m_err = 1'b1;
               end
               m_num = 0;
               m_nd  = 0;
            end
         end else if (code == 4'hB) begin
            m_num = 0;
            m_nd  = 0;
         end
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("elem_flat", elem_flat, m_flat());
         check("entry_bcd", {52'd0, entry_bcd}, {52'd0, m_bcd()});
         check("digit_cnt", {62'd0, digit_cnt}, 64'(m_nd));
         check("wr_idx",    {61'd0, wr_idx},    64'(m_idx));
         check("wr_pulse",  {63'd0, wr_pulse},  {63'd0, m_pulse});
         check("err",       {63'd0, err},       {63'd0, m_err});
         check("done",      {63'd0, done},      {63'd0, m_done});
         if (wr_pulse === 1'b1) pulse_seen++;
      end
   end

   task automatic cycle(input bit kv, input logic [3:0] code);
      key_valid = kv;
      key_code  = code;
      @(posedge clk);
      model_step(kv, code);
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] code);
      cycle(1'b1, code);
      cycle(1'b0, 4'h0);
   endtask

   task automatic hold(input logic [3:0] code, input int n);
      repeat (n) cycle(1'b1, code);
      cycle(1'b0, 4'h0);
   endtask

   // Asserts reset away from any clock edge and checks outputs before the next edge.
   task automatic apply_reset();
      chk_en    = 1'b0;
      key_valid = 1'b0;
      resetn    = 1'b0;
      #1;
      check("rst_elem",  elem_flat, 64'd0);
      check("rst_entry", {52'd0, entry_bcd}, 64'd0);
      check("rst_cnt",   {62'd0, digit_cnt}, 64'd0);
      check("rst_idx",   {61'd0, wr_idx}, 64'd0);
      check("rst_flags", {61'd0, wr_pulse, err, done}, 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      logic [3:0] code;
      int r;
      #2;
      apply_reset();

      // Scenario 1: 1,2,3,ENTER stores 123.
      p = pulse_seen;
      press(4'd1); press(4'd2); press(4'd3); press(4'hA);
      check("t1_pulses", 64'(pulse_seen - p), 64'd1);
      check("t1_elem0",  {56'd0, elem_flat[7:0]}, 64'd123);
      check("t1_idx",    {61'd0, wr_idx}, 64'd1);
      check("t1_entry",  {52'd0, entry_bcd}, 64'd0);
      check("t1_err",    {63'd0, err}, 64'd0);

      // Scenario 2: 256 rejected, next press clears err.
      p = pulse_seen;
      press(4'd2); press(4'd5); press(4'd6); press(4'hA);
      check("t2_err",    {63'd0, err}, 64'd1);
      check("t2_pulses", 64'(pulse_seen - p), 64'd0);
      check("t2_idx",    {61'd0, wr_idx}, 64'd1);
      press(4'd7);
      check("t2_err_clr", {63'd0, err}, 64'd0);
      check("t2_entry",   {52'd0, entry_bcd}, 64'h007);
      press(4'hB);

      // Scenario 3: fourth digit ignored, CLEAR, empty ENTER.
      press(4'd9); press(4'd8); press(4'd7); press(4'd6);
      check("t3_entry", {52'd0, entry_bcd}, 64'h987);
      check("t3_cnt",   {62'd0, digit_cnt}, 64'd3);
      press(4'hB);
      check("t3_clr_entry", {52'd0, entry_bcd}, 64'd0);
      check("t3_clr_cnt",   {62'd0, digit_cnt}, 64'd0);
      p = pulse_seen;
      press(4'hA);
      check("t3_pulses", 64'(pulse_seen - p), 64'd0);
      check("t3_idx",    {61'd0, wr_idx}, 64'd1);

      // Scenario 4: fill all eight elements, DONE behaviour.
      #2;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         press(4'(i));
         press(4'hA);
      end
      check("t4_flat", elem_flat, 64'h0706050403020100);
      check("t4_done", {63'd0, done}, 64'd1);
      check("t4_idx",  {61'd0, wr_idx}, 64'd7);
      press(4'hA); press(4'd3); press(4'hA);
      check("t4_flat_hold", elem_flat, 64'h0706050403020100);
      check("t4_done_hold", {63'd0, done}, 64'd1);
      check("t4_entry",     {52'd0, entry_bcd}, 64'd0);
      press(4'hB);
      check("t4_done_clr", {63'd0, done}, 64'd0);
      check("t4_idx_clr",  {61'd0, wr_idx}, 64'd0);

      // Scenario 5: long hold gives one digit.
      p = pulse_seen;
      hold(4'd5, 50);
      press(4'hA);
      check("t5_elem0",  {56'd0, elem_flat[7:0]}, 64'd5);
      check("t5_pulses", 64'(pulse_seen - p), 64'd1);
      check("t5_idx",    {61'd0, wr_idx}, 64'd1);

      // Scenario 6: asynchronous reset in the middle of an entry.
      press(4'd9); press(4'hA); press(4'd9); press(4'hA);
      press(4'd1); press(4'd2);
      check("t6_cnt", {62'd0, digit_cnt}, 64'd2);
      check("t6_idx", {61'd0, wr_idx}, 64'd3);
      #2;
      apply_reset();

      // Random key traffic; code may wander while the key is held.
      repeat (450) begin
         r = $urandom_range(0, 99);
         if (r < 60)      code = 4'($urandom_range(0, 9));
         else if (r < 80) code = 4'hA;
         else if (r < 87) code = 4'hB;
         else             code = 4'($urandom_range(12, 15));
         if ($urandom_range(0, 149) == 0) begin
            #2;
            apply_reset();
         end
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            cycle(1'b1, (j == 0) ? code : 4'($urandom));
         end
         repeat ($urandom_range(1, 2)) cycle(1'b0, 4'($urandom));
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
